// File: rtl/imuldiv_int_div_iterative_param.sv
`default_nettype none
// ============================================================================
// Module   : imuldiv_int_div_iterative_param
// Brief    : Width-generic iterative restoring divider (one step per cycle),
//            signed/unsigned, RISC-V divide-by-zero, registered val/rdy response.
// Revision : 1.0 - initial release
// ============================================================================
module imuldiv_int_div_iterative_param #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 divreq_msg_fn,
    input  logic [WIDTH-1:0]     divreq_msg_a,
    input  logic [WIDTH-1:0]     divreq_msg_b,
    input  logic                 divreq_val,
    output logic                 divreq_rdy,
    output logic [2*WIDTH-1:0]   divresp_msg_result,
    output logic                 divresp_val,
    input  logic                 divresp_rdy,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_cnt_init = CW'(WIDTH - 1);

    state_t               r_state;
    logic                 r_fn;
    logic                 r_q_sign;
    logic                 r_r_sign;
    logic [2*WIDTH:0]     r_work;
    logic [2*WIDTH:0]     r_divisor;
    logic [CW-1:0]        r_counter;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_req_fire;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_b_zero;
    logic [2*WIDTH:0]     w_shifted;
    logic [2*WIDTH:0]     w_diff;
    logic [2*WIDTH:0]     w_work_next;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic                 w_unused;

    // A response being consumed frees the unit for a new request in the same cycle
    assign divreq_rdy         = (r_state == S_IDLE) | ((r_state == S_DONE) & divresp_rdy);
    assign divresp_val        = (r_state == S_DONE);
    assign busy               = (r_state == S_CALC);
    assign divresp_msg_result = r_result;

    assign w_req_fire = divreq_val & divreq_rdy;
    assign w_a_mag    = (divreq_msg_fn & divreq_msg_a[WIDTH-1]) ? -divreq_msg_a : divreq_msg_a;
    assign w_b_mag    = (divreq_msg_fn & divreq_msg_b[WIDTH-1]) ? -divreq_msg_b : divreq_msg_b;
    assign w_b_zero   = (divreq_msg_b == '0);

    assign w_shifted   = r_work << 1;
    assign w_diff      = w_shifted - r_divisor;
    assign w_work_next = w_diff[2*WIDTH] ? w_shifted : {w_diff[2*WIDTH:1], 1'b1};

    assign w_quot     = w_work_next[WIDTH-1:0];
    assign w_rem      = w_work_next[2*WIDTH-1:WIDTH];
    assign w_quot_fix = (r_fn & r_q_sign) ? -w_quot : w_quot;
    assign w_rem_fix  = (r_fn & r_r_sign) ? -w_rem  : w_rem;

    // Top work bit is always zero after a restore; diff LSB is replaced by the quotient bit
    assign w_unused = ^{r_work[2*WIDTH], w_work_next[2*WIDTH], w_diff[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_fn      <= 1'b0;
            r_q_sign  <= 1'b0;
            r_r_sign  <= 1'b0;
            r_work    <= '0;
            r_divisor <= '0;
            r_counter <= c_cnt_init;
            r_result  <= '0;
        end else if (w_req_fire) begin
            r_fn      <= divreq_msg_fn;
            r_q_sign  <= divreq_msg_a[WIDTH-1] ^ divreq_msg_b[WIDTH-1];
            r_r_sign  <= divreq_msg_a[WIDTH-1];
            r_work    <= {{(WIDTH+1){1'b0}}, w_a_mag};
            r_divisor <= {1'b0, w_b_mag, {WIDTH{1'b0}}};
            r_counter <= c_cnt_init;
            if (w_b_zero) begin
                r_state  <= S_DONE;
                r_result <= {divreq_msg_a, {WIDTH{1'b1}}};
            end else begin
                r_state  <= S_CALC;
            end
        end else begin
            case (r_state)
                S_CALC: begin
                    r_work <= w_work_next;
                    if (r_counter == '0) begin
                        r_state  <= S_DONE;
                        r_result <= {w_rem_fix, w_quot_fix};
                    end else begin
                        r_counter <= r_counter - 1'b1;
                    end
                end
                S_DONE: begin
                    if (divresp_rdy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imuldiv_int_div_iterative_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_imuldiv_int_div_iterative_param
// Brief    : Directed self-checking bench for the 32-bit and 8-bit dividers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imuldiv_int_div_iterative_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        fn;
    logic [31:0] a;
    logic [31:0] b;

    logic        val32, resp_rdy32, req_rdy32, resp_val32, busy32;
    logic [63:0] res32;
    logic        val8, resp_rdy8, req_rdy8, resp_val8, busy8;
    logic [15:0] res8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imuldiv_int_div_iterative_param #(.WIDTH(32)) dut32 (
        .clk                (clk),
        .reset              (reset),
        .divreq_msg_fn      (fn),
        .divreq_msg_a       (a),
        .divreq_msg_b       (b),
        .divreq_val         (val32),
        .divreq_rdy         (req_rdy32),
        .divresp_msg_result (res32),
        .divresp_val        (resp_val32),
        .divresp_rdy        (resp_rdy32),
        .busy               (busy32)
    );

    imuldiv_int_div_iterative_param #(.WIDTH(8)) dut8 (
        .clk                (clk),
        .reset              (reset),
        .divreq_msg_fn      (fn),
        .divreq_msg_a       (a[7:0]),
        .divreq_msg_b       (b[7:0]),
        .divreq_val         (val8),
        .divreq_rdy         (req_rdy8),
        .divresp_msg_result (res8),
        .divresp_val        (resp_val8),
        .divresp_rdy        (resp_rdy8),
        .busy               (busy8)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic issue(input bit sel8, input logic f, input logic [31:0] da, input logic [31:0] db);
        fn = f;
        a  = da;
        b  = db;
        if (sel8) val8 = 1'b1;
        else      val32 = 1'b1;
    endtask

    // Waits for the response counting edges from the accept edge, then optionally consumes it
    task automatic await_resp(input string tag, input bit sel8, input logic [63:0] exp,
                              input int exp_lat, input bit exp_busy, input bit consume);
        int n = 0;
        bit busy_seen = 1'b0;
        bit v;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                val32 = 1'b0; val8 = 1'b0; resp_rdy32 = 1'b0; resp_rdy8 = 1'b0;
                a = ~a; b = ~b; fn = ~fn;
            end
            busy_seen = busy_seen | (sel8 ? busy8 : busy32);
            v = sel8 ? resp_val8 : resp_val32;
        end while (!v && n < 200);
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_res"}, sel8 ? {48'b0, res8} : res32, exp);
        chk({tag, "_busy"}, 64'(busy_seen), 64'(exp_busy));
        chk({tag, "_reqrdy"}, 64'(sel8 ? req_rdy8 : req_rdy32), 64'd0);
        if (consume) begin
            if (sel8) resp_rdy8 = 1'b1;
            else      resp_rdy32 = 1'b1;
            @(posedge clk); #1;
            resp_rdy32 = 1'b0; resp_rdy8 = 1'b0;
            chk({tag, "_idle"}, 64'(sel8 ? resp_val8 : resp_val32), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fn = 1'b0; a = '0; b = '0;
        val32 = 1'b0; resp_rdy32 = 1'b0; val8 = 1'b0; resp_rdy8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy32",  64'(req_rdy32),  64'd1);
        chk("rst_val32",  64'(resp_val32), 64'd0);
        chk("rst_busy32", 64'(busy32),     64'd0);
        chk("rst_res32",  res32,           64'd0);
        chk("rst_rdy8",   64'(req_rdy8),   64'd1);
        chk("rst_res8",   64'(res8),       64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue(0, 1'b0, 32'd100, 32'd7);
        await_resp("u100_7", 0, 64'h00000002_0000000E, 33, 1, 1);
        issue(0, 1'b1, 32'hFFFFFFF9, 32'd2);
        await_resp("s_m7_2", 0, 64'hFFFFFFFF_FFFFFFFD, 33, 1, 1);
        issue(0, 1'b1, 32'd7, 32'hFFFFFFFE);
        await_resp("s_7_m2", 0, 64'h00000001_FFFFFFFD, 33, 1, 1);
        issue(0, 1'b0, 32'hFFFFFFF9, 32'd2);
        await_resp("u_big_2", 0, 64'h00000001_7FFFFFFC, 33, 1, 1);
        issue(0, 1'b1, 32'h12345678, 32'd0);
        await_resp("dz_s", 0, 64'h12345678_FFFFFFFF, 1, 0, 1);
        issue(0, 1'b0, 32'h12345678, 32'd0);
        await_resp("dz_u", 0, 64'h12345678_FFFFFFFF, 1, 0, 1);
        issue(0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        await_resp("ovf", 0, 64'h00000000_80000000, 33, 1, 1);

        // Back-pressure, then back-to-back handoff
        issue(0, 1'b0, 32'd100, 32'd7);
        await_resp("bp", 0, 64'h00000002_0000000E, 33, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_res",    res32,             64'h00000002_0000000E);
            chk("bp_val",    64'(resp_val32),   64'd1);
            chk("bp_reqrdy", 64'(req_rdy32),    64'd0);
        end
        issue(0, 1'b0, 32'd50, 32'd5);
        resp_rdy32 = 1'b1;
        #1;
        chk("b2b_reqrdy", 64'(req_rdy32), 64'd1);
        await_resp("b2b", 0, 64'h00000000_0000000A, 33, 1, 1);

        // Asynchronous reset between edges while mid-calculation
        issue(0, 1'b0, 32'd1000, 32'd3);
        @(posedge clk); #1;
        val32 = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy32), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_val",  64'(resp_val32), 64'd0);
        chk("ar_rdy",  64'(req_rdy32),  64'd1);
        chk("ar_busy", 64'(busy32),     64'd0);
        chk("ar_res",  res32,           64'd0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(0, 1'b0, 32'd9, 32'd4);
        await_resp("post_rst", 0, 64'h00000001_00000002, 33, 1, 1);

        issue(1, 1'b1, 32'h000000F9, 32'h00000003);
        await_resp("w8_s", 1, 64'h000000000000FFFE, 9, 1, 1);
        issue(1, 1'b0, 32'h000000FF, 32'h00000010);
        await_resp("w8_u", 1, 64'h0000000000000F0F, 9, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imuldiv_int_div_iterative_param.md
Name: imuldiv_int_div_iterative_param

Overview:
- Parametrised, width-generic successor of the iterative integer divider in the imuldiv unit.
- Performs one restoring-division step per cycle and produces `{remainder, quotient}` for signed or unsigned operands.
- Adds RISC-V divide-by-zero semantics with an early-out path.
- Adds a fully registered response and back-to-back request acceptance on the same cycle a response is consumed.
- Sits behind the muldiv request/response val/rdy interface.

Parameters:
- WIDTH, 32, operand width in bits (must be >= 2). Result width is 2*WIDTH.
- CW, $clog2(WIDTH), step-counter width (derived; not overridden by users).

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- divreq_msg_fn  input  1  1 = signed divide/remainder, 0 = unsigned
- divreq_msg_a  input  WIDTH  dividend
- divreq_msg_b  input  WIDTH  divisor
- divreq_val  input  1  request valid
- divreq_rdy  output  1  request ready
- divresp_msg_result  output  2*WIDTH  `{remainder[WIDTH-1:0], quotient[WIDTH-1:0]}`
- divresp_val  output  1  response valid
- divresp_rdy  input  1  response ready
- busy  output  1  high while in CALC

Behaviour:
- Reset (async, takes effect immediately regardless of clk):
  - state = IDLE; divreq_rdy = 1; divresp_val = 0; busy = 0.
  - divresp_msg_result = 0; counter = WIDTH-1.
  - Reset mid-operation discards the in-flight division; no response is produced for it.
- States: IDLE, CALC, DONE.
- Handshakes:
  - Request fires when divreq_val & divreq_rdy.
  - Response fires when divresp_val & divresp_rdy.
  - divreq_rdy = (state==IDLE) | (state==DONE & divresp_rdy). It is combinational from state and divresp_rdy and never depends on divreq_val.
  - divresp_val = (state==DONE).
- On request fire:
  - Latch fn.
  - Latch quotient sign = a[W-1]^b[W-1] and remainder sign = a[W-1], used only when fn=1.
  - Load magnitudes: two's-complement negate a and b when fn=1 and their MSB is set.
  - Working register = {(W+1)'b0, |a|}; divisor register = {1'b0, |b|, W'b0}; counter = WIDTH-1.
  - If b==0: next state is DONE with result = {a (raw), all-ones}. This applies in both signed and unsigned modes. CALC is skipped.
  - Otherwise: next state is CALC.
- CALC, each cycle:
  - shifted = work<<1; diff = shifted - divisor (2W+1 bits).
  - If diff MSB == 1: work = shifted. Otherwise: work = {diff[2W:1], 1'b1}.
  - counter decrements by 1.
  - When the step with counter==0 completes, go to DONE. Exactly WIDTH steps are performed; the counter never wraps.
- Entering DONE from CALC:
  - quotient = work[W-1:0], negated if fn & quotient sign.
  - remainder = work[2W-1:W], negated if fn & remainder sign.
  - Both are written into the result register, so the output is not combinational from working state.
- Latency, with the accept cycle as cycle 0:
  - Normal division: CALC occupies cycles 1..WIDTH; divresp_val first high in cycle WIDTH+1.
  - Divide by zero: divresp_val high in cycle 1.
- DONE:
  - divresp_msg_result and divresp_val hold stable while divresp_rdy=0.
  - On response fire with divreq_val=1, the new request is accepted in the same cycle and the next state is CALC (or DONE if b==0).
  - On response fire without a request, the next state is IDLE.
- Signed overflow (a = most-negative, b = -1) needs no special case: the datapath yields quotient = most-negative and remainder = 0.
- Operand inputs are sampled only on request fire. Changing them at any other time has no effect.

Test Plan:
- Unsigned, WIDTH=32: a=100, b=7, fn=0 -> result {32'd2, 32'd14}; divresp_val first high exactly 33 cycles after the accept cycle.
- Signed: a=-7 (0xFFFFFFF9), b=2, fn=1 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also a=7, b=-2 -> quotient 0xFFFFFFFD, remainder 1.
- Divide by zero: a=0x12345678, b=0, fn=1 then fn=0 -> result {0x12345678, 0xFFFFFFFF}, divresp_val in cycle 1, busy never asserted. Signed overflow: a=0x80000000, b=0xFFFFFFFF, fn=1 -> {0, 0x80000000}.
- Back-pressure and back-to-back:
  - Hold divresp_rdy=0 for 5 cycles in DONE -> result and val stable, divreq_rdy=0.
  - Then raise divresp_rdy with divreq_val=1 (a=50, b=5) -> old response fires and new request is accepted in the same cycle; next result {0, 10}.
- Async reset asserted mid-CALC (counter≈15), between clock edges -> divresp_val=0, divreq_rdy=1, busy=0 immediately. The post-reset request 9/4 returns {1, 2} with no stale response.
- WIDTH=8 instance: a=0xF9 (-7), b=0x03, fn=1 -> quotient 0xFE, remainder 0xFF. Unsigned 0xFF/0x10 -> {0x0F, 0x0F}; latency 9 cycles.
